reg_bank_seq: RTL and testbench
===============================

REG_BANK_SEQ -- requirements
Module: reg_bank_seq

Interface
REQ-001 Parameter DATA_W, 32, register and bus width in bits.
REQ-002 Parameter NUM_REGS, 16, number of architectural registers (power of two, >=4); ADDR_W = clog2(NUM_REGS).
REQ-003 Parameter SP_IDX, 13, index of the stack register exported on ST.
REQ-004 Parameter SP_INIT, 0, reset value of register SP_IDX.
REQ-005 Parameter BYPASS, 1, 1 = read ports return same-cycle write data; 0 = read ports return stored data.
REQ-006 clk  in  1  single clock; all state updates on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 wr_en  in  1  write register wr_addr with wr_data.
REQ-009 wr_addr  in  ADDR_W  write destination.
REQ-010 wr_data  in  DATA_W  write data.
REQ-011 pc_inc  in  1  add 4 to register NUM_REGS-1 (PC).
REQ-012 rn_addr / rm_addr / rs_addr  in  ADDR_W each  read-port addresses.
REQ-013 gate_b / gate_c  in  1 each  enable drive of b_bus / c_bus.
REQ-014 a_bus  out  DATA_W  Rn data, always driven.
REQ-015 b_bus / c_bus  out  DATA_W  Rm / Rs data when gated, else high-Z.
REQ-016 st / pc  out  DATA_W  current contents of register SP_IDX / NUM_REGS-1.
REQ-017 lsm_start  in  1  begin a load/store-multiple sequence.
REQ-018 lsm_list  in  NUM_REGS  register list, bit i = register i.
REQ-019 lsm_ascending  in  1  1 = lowest index first, 0 = highest first.
REQ-020 lsm_advance  in  1  consumer accepts current lsm_reg.
REQ-021 lsm_busy  out  1  sequencer not IDLE.
REQ-022 lsm_valid / lsm_reg / lsm_last  out  1 / ADDR_W / 1  current register offered; lsm_last = it is the final one.
REQ-023 lsm_count  out  ADDR_W+1  popcount of list latched at start.
REQ-024 lsm_done  out  1  one-cycle completion pulse.

Function
REQ-025 Reads are combinational; with BYPASS=1 and wr_en with wr_addr equal to a read address, that port SHALL return wr_data.
REQ-026 Write priority on PC: wr_en to PC wins over pc_inc; otherwise pc_inc adds 4 modulo 2^DATA_W; wr_en to another register and pc_inc SHALL both take effect in one cycle.
REQ-027 Sequencer states IDLE, RUN, DONE; lsm_start ignored unless IDLE.
REQ-028 IDLE + lsm_start: latch lsm_list, lsm_ascending and lsm_count; next state RUN if list non-zero, else DONE.
REQ-029 RUN: lsm_valid=1, lsm_reg = lowest (ascending) or highest (descending) set bit of remaining list; lsm_last=1 when exactly one bit remains.
REQ-030 RUN + lsm_advance: clear that bit next edge; if lsm_last, next state DONE; without lsm_advance, outputs hold.
REQ-031 DONE: lsm_done=1 for exactly one cycle, lsm_valid=0, then IDLE; a new sequence may start the following cycle.
REQ-032 Start-to-first-valid latency SHALL be one cycle; one register per cycle under continuous lsm_advance.
REQ-033 lsm_valid, lsm_last, lsm_done SHALL be 0 outside RUN/DONE as stated; lsm_reg SHALL be 0 when lsm_valid=0.

Reset
REQ-034 rst SHALL set all registers to 0 except SP_IDX = SP_INIT, state IDLE, latched list and lsm_count to 0.
REQ-035 rst SHALL take priority over wr_en, pc_inc and lsm_start in the same cycle and abort any sequence without a lsm_done pulse.

Structure
REQ-036 State encoding and default parameter constants SHALL live in shared package reg_bank_pkg.
REQ-037 The list sequencer SHALL be a sub-module lsm_sequencer; register array and ports stay in reg_bank_seq.

Verification
REQ-038 Reset with SP_INIT=0x1000 -> st=0x1000, pc=0, all reads 0, lsm_busy=0.
REQ-039 wr_en addr 3 data 0xDEADBEEF with rn_addr=3, BYPASS=1 -> a_bus=0xDEADBEEF same cycle; BYPASS=0 -> old value, new value next cycle.
REQ-040 pc=0xFFFFFFFC, pc_inc=1 -> pc=0; pc_inc with wr_en addr 15 data 0x100 -> pc=0x100.
REQ-041 lsm_list=0x8005 ascending, lsm_advance held high -> lsm_reg 0,2,15 on consecutive cycles, lsm_last on 15, lsm_count=3, lsm_done one cycle after.
REQ-042 Same list descending, lsm_advance stalled 2 cycles on first -> 15 held 3 cycles, then 2, 0; lsm_list=0 -> lsm_done one cycle after start, no lsm_valid.
REQ-043 rst asserted mid-RUN -> IDLE next cycle, lsm_valid=0, no lsm_done; lsm_start while RUN -> ignored.

Source files
------------

// File: rtl/reg_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_pkg
// Description : Shared sequencer state encoding and default bank constants.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_bank_pkg;

    localparam int          c_def_data_w   = 32;
    localparam int          c_def_num_regs = 16;
    localparam int          c_def_sp_idx   = 13;
    localparam logic [31:0] c_def_sp_init  = 32'h0000_0000;
    localparam int          c_def_bypass   = 1;
    localparam int          c_pc_step      = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } lsm_state_t;

endpackage
`default_nettype wire

// File: rtl/lsm_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lsm_sequencer
// Description : Walks a latched register list one index per accepted cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module lsm_sequencer
    import reg_bank_pkg::*;
#(
    parameter  int NUM_REGS = c_def_num_regs,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lsm_start,
    input  logic [NUM_REGS-1:0] lsm_list,
    input  logic                lsm_ascending,
    input  logic                lsm_advance,
    output logic                lsm_busy,
    output logic                lsm_valid,
    output logic [ADDR_W-1:0]   lsm_reg,
    output logic                lsm_last,
    output logic [ADDR_W:0]     lsm_count,
    output logic                lsm_done
);

    localparam logic [NUM_REGS-1:0] c_one = NUM_REGS'(1);

    function automatic logic [ADDR_W-1:0] pick(input logic [NUM_REGS-1:0] l, input logic asc);
        logic [ADDR_W-1:0] idx;
        idx = '0;
        if (asc) begin
            for (int i = NUM_REGS - 1; i >= 0; i--) begin
                if (l[i]) idx = ADDR_W'(i);
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (l[i]) idx = ADDR_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [ADDR_W:0] popcount(input logic [NUM_REGS-1:0] l);
        logic [ADDR_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt = cnt + (ADDR_W+1)'(l[i]);
        end
        return cnt;
    endfunction

    lsm_state_t          r_state;
    logic [NUM_REGS-1:0] r_list;
    logic                r_asc;
    logic [ADDR_W:0]     r_count;
    logic                r_busy;
    logic                r_valid;
    logic [ADDR_W-1:0]   r_reg;
    logic                r_last;
    logic                r_done;

    lsm_state_t          w_next_state;
    logic [NUM_REGS-1:0] w_next_list;
    logic                w_next_asc;
    logic [ADDR_W:0]     w_next_count;
    logic                w_next_run;

    always_comb begin
        w_next_state = r_state;
        w_next_list  = r_list;
        w_next_asc   = r_asc;
        w_next_count = r_count;
        case (r_state)
            ST_IDLE: begin
                if (lsm_start) begin
                    w_next_list  = lsm_list;
                    w_next_asc   = lsm_ascending;
                    w_next_count = popcount(lsm_list);
                    w_next_state = (|lsm_list) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (lsm_advance) begin
                    w_next_list = r_list & ~(c_one << r_reg);
                    if (r_last) w_next_state = ST_DONE;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
        w_next_run = (w_next_state == ST_RUN);
    end

    // Outputs are computed from the next-state view so they are registered yet
    // still show the first list entry the cycle after start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_list  <= '0;
            r_asc   <= 1'b0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_reg   <= '0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_list  <= w_next_list;
            r_asc   <= w_next_asc;
            r_count <= w_next_count;
            r_busy  <= (w_next_state != ST_IDLE);
            r_valid <= w_next_run;
            r_reg   <= w_next_run ? pick(w_next_list, w_next_asc) : '0;
            r_last  <= w_next_run && (w_next_list != '0)
                       && ((w_next_list & (w_next_list - c_one)) == '0);
            r_done  <= (w_next_state == ST_DONE);
        end
    end

    assign lsm_busy  = r_busy;
    assign lsm_valid = r_valid;
    assign lsm_reg   = r_reg;
    assign lsm_last  = r_last;
    assign lsm_count = r_count;
    assign lsm_done  = r_done;

endmodule
`default_nettype wire

// File: rtl/reg_bank_seq.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_seq
// Description : Register bank with three read buses, PC/stack taps and an LSM list sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bank_seq
    import reg_bank_pkg::*;
#(
    parameter  int                DATA_W   = c_def_data_w,
    parameter  int                NUM_REGS = c_def_num_regs,
    parameter  int                SP_IDX   = c_def_sp_idx,
    parameter  logic [DATA_W-1:0] SP_INIT  = DATA_W'(c_def_sp_init),
    parameter  int                BYPASS   = c_def_bypass,
    localparam int                ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                pc_inc,
    input  logic [ADDR_W-1:0]   rn_addr,
    input  logic [ADDR_W-1:0]   rm_addr,
    input  logic [ADDR_W-1:0]   rs_addr,
    input  logic                gate_b,
    input  logic                gate_c,
    output logic [DATA_W-1:0]   a_bus,
    output logic [DATA_W-1:0]   b_bus,
    output logic [DATA_W-1:0]   c_bus,
    output logic [DATA_W-1:0]   st,
    output logic [DATA_W-1:0]   pc,
    input  logic                lsm_start,
    input  logic [NUM_REGS-1:0] lsm_list,
    input  logic                lsm_ascending,
    input  logic                lsm_advance,
    output logic                lsm_busy,
    output logic                lsm_valid,
    output logic [ADDR_W-1:0]   lsm_reg,
    output logic                lsm_last,
    output logic [ADDR_W:0]     lsm_count,
    output logic                lsm_done
);

    localparam int PC_IDX = NUM_REGS - 1;

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] w_rn;
    logic [DATA_W-1:0] w_rm;
    logic [DATA_W-1:0] w_rs;

    // The explicit write is issued after the increment so it wins on PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
            end
        end else begin
            if (pc_inc) r_regs[PC_IDX] <= r_regs[PC_IDX] + DATA_W'(c_pc_step);
            if (wr_en)  r_regs[wr_addr] <= wr_data;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        if ((BYPASS != 0) && wr_en && (wr_addr == addr)) return wr_data;
        return r_regs[addr];
    endfunction

    always_comb begin
        w_rn = read_port(rn_addr);
        w_rm = read_port(rm_addr);
        w_rs = read_port(rs_addr);
    end

    assign a_bus = w_rn;
    assign b_bus = gate_b ? w_rm : 'z;
    assign c_bus = gate_c ? w_rs : 'z;
    assign st    = r_regs[SP_IDX];
    assign pc    = r_regs[PC_IDX];

    lsm_sequencer #(
        .NUM_REGS (NUM_REGS)
    ) u_lsm (
        .clk           (clk),
        .rst           (rst),
        .lsm_start     (lsm_start),
        .lsm_list      (lsm_list),
        .lsm_ascending (lsm_ascending),
        .lsm_advance   (lsm_advance),
        .lsm_busy      (lsm_busy),
        .lsm_valid     (lsm_valid),
        .lsm_reg       (lsm_reg),
        .lsm_last      (lsm_last),
        .lsm_count     (lsm_count),
        .lsm_done      (lsm_done)
    );

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_bank_seq
// Description : Directed self-checking bench for reg_bank_seq (bypass and stored-read builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_bank_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        pc_inc;
    logic [3:0]  rn_addr, rm_addr, rs_addr;
    logic        gate_b, gate_c;
    logic        lsm_start;
    logic [15:0] lsm_list;
    logic        lsm_ascending;
    logic        lsm_advance;

    wire  [31:0] a_bus, b_bus, c_bus, st, pc;
    wire         lsm_busy, lsm_valid, lsm_last, lsm_done;
    wire  [3:0]  lsm_reg;
    wire  [4:0]  lsm_count;

    wire  [31:0] nb_a_bus, nb_b_bus, nb_c_bus, nb_st, nb_pc;
    wire         nb_busy, nb_valid, nb_last, nb_done;
    wire  [3:0]  nb_reg;
    wire  [4:0]  nb_count;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    reg_bank_seq #(
        .DATA_W(32), .NUM_REGS(16), .SP_IDX(13), .SP_INIT(32'h1000), .BYPASS(1)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pc_inc(pc_inc), .rn_addr(rn_addr), .rm_addr(rm_addr), .rs_addr(rs_addr),
        .gate_b(gate_b), .gate_c(gate_c), .a_bus(a_bus), .b_bus(b_bus), .c_bus(c_bus),
        .st(st), .pc(pc), .lsm_start(lsm_start), .lsm_list(lsm_list),
        .lsm_ascending(lsm_ascending), .lsm_advance(lsm_advance), .lsm_busy(lsm_busy),
        .lsm_valid(lsm_valid), .lsm_reg(lsm_reg), .lsm_last(lsm_last),
        .lsm_count(lsm_count), .lsm_done(lsm_done)
    );

    reg_bank_seq #(
        .DATA_W(32), .NUM_REGS(16), .SP_IDX(13), .SP_INIT(32'h1000), .BYPASS(0)
    ) dut_nb (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pc_inc(pc_inc), .rn_addr(rn_addr), .rm_addr(rm_addr), .rs_addr(rs_addr),
        .gate_b(gate_b), .gate_c(gate_c), .a_bus(nb_a_bus), .b_bus(nb_b_bus), .c_bus(nb_c_bus),
        .st(nb_st), .pc(nb_pc), .lsm_start(lsm_start), .lsm_list(lsm_list),
        .lsm_ascending(lsm_ascending), .lsm_advance(lsm_advance), .lsm_busy(nb_busy),
        .lsm_valid(nb_valid), .lsm_reg(nb_reg), .lsm_last(nb_last),
        .lsm_count(nb_count), .lsm_done(nb_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected sequencer view: valid, reg, last, done, busy.
    task automatic chk_lsm(input string tag, input logic v, input logic [3:0] r,
                           input logic l, input logic d, input logic b);
        chk({tag, ".valid"}, {31'd0, lsm_valid}, {31'd0, v});
        chk({tag, ".reg"},   {28'd0, lsm_reg},   {28'd0, r});
        chk({tag, ".last"},  {31'd0, lsm_last},  {31'd0, l});
        chk({tag, ".done"},  {31'd0, lsm_done},  {31'd0, d});
        chk({tag, ".busy"},  {31'd0, lsm_busy},  {31'd0, b});
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; pc_inc = 1'b0;
        rn_addr = '0; rm_addr = 4'd5; rs_addr = 4'd7; gate_b = 1'b1; gate_c = 1'b1;
        lsm_start = 1'b0; lsm_list = '0; lsm_ascending = 1'b0; lsm_advance = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst.st", st, 32'h1000);
        chk("rst.pc", pc, 32'h0);
        chk("rst.a_bus", a_bus, 32'h0);
        chk("rst.b_bus", b_bus, 32'h0);
        chk("rst.c_bus", c_bus, 32'h0);
        chk("rst.count", {27'd0, lsm_count}, 32'd0);
        chk_lsm("rst", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        // Same-cycle bypass versus stored read
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hDEAD_BEEF; rn_addr = 4'd3;
        #1;
        chk("byp.a_bus", a_bus, 32'hDEAD_BEEF);
        chk("nobyp.a_bus_old", nb_a_bus, 32'h0);
        step();
        wr_en = 1'b0;
        #1;
        chk("nobyp.a_bus_new", nb_a_bus, 32'hDEAD_BEEF);
        chk("byp.a_bus_stored", a_bus, 32'hDEAD_BEEF);
        rm_addr = 4'd3; rs_addr = 4'd13;
        #1;
        chk("b_bus.r3", b_bus, 32'hDEAD_BEEF);
        chk("c_bus.sp", c_bus, 32'h1000);

        // PC wrap and write priority
        wr_en = 1'b1; wr_addr = 4'd15; wr_data = 32'hFFFF_FFFC;
        step();
        wr_en = 1'b0;
        chk("pc.load", pc, 32'hFFFF_FFFC);
        pc_inc = 1'b1;
        step();
        chk("pc.wrap", pc, 32'h0);
        wr_en = 1'b1; wr_addr = 4'd15; wr_data = 32'h100;
        step();
        chk("pc.wr_wins", pc, 32'h100);
        wr_addr = 4'd4; wr_data = 32'h55;
        step();
        wr_en = 1'b0; pc_inc = 1'b0; rn_addr = 4'd4;
        #1;
        chk("pc.inc_with_wr", pc, 32'h104);
        chk("r4.concurrent", a_bus, 32'h55);

        // Ascending 0x8005, continuous advance
        lsm_start = 1'b1; lsm_list = 16'h8005; lsm_ascending = 1'b1; lsm_advance = 1'b1;
        step();
        lsm_start = 1'b0;
        chk("asc.count", {27'd0, lsm_count}, 32'd3);
        chk_lsm("asc0", 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
        step();
        chk_lsm("asc1", 1'b1, 4'd2, 1'b0, 1'b0, 1'b1);
        step();
        chk_lsm("asc2", 1'b1, 4'd15, 1'b1, 1'b0, 1'b1);
        step();
        chk_lsm("asc.done", 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        step();
        chk_lsm("asc.idle", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        // Descending with a two-cycle stall on the first entry
        lsm_start = 1'b1; lsm_ascending = 1'b0; lsm_advance = 1'b0;
        step();
        lsm_start = 1'b0;
        chk_lsm("dsc.hold0", 1'b1, 4'd15, 1'b0, 1'b0, 1'b1);
        step();
        chk_lsm("dsc.hold1", 1'b1, 4'd15, 1'b0, 1'b0, 1'b1);
        step();
        lsm_advance = 1'b1;
        chk_lsm("dsc.hold2", 1'b1, 4'd15, 1'b0, 1'b0, 1'b1);
        step();
        chk_lsm("dsc1", 1'b1, 4'd2, 1'b0, 1'b0, 1'b1);
        step();
        chk_lsm("dsc2", 1'b1, 4'd0, 1'b1, 1'b0, 1'b1);
        step();
        chk_lsm("dsc.done", 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        step();

        // Empty list goes straight to DONE
        lsm_start = 1'b1; lsm_list = 16'h0000;
        step();
        lsm_start = 1'b0;
        chk("empty.count", {27'd0, lsm_count}, 32'd0);
        chk_lsm("empty.done", 1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        step();
        chk_lsm("empty.idle", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        // Start ignored while running, then reset aborts mid-RUN
        lsm_start = 1'b1; lsm_list = 16'h0012; lsm_ascending = 1'b1; lsm_advance = 1'b0;
        step();
        lsm_list = 16'h0001;
        chk_lsm("run.first", 1'b1, 4'd1, 1'b0, 1'b0, 1'b1);
        step();
        lsm_start = 1'b0;
        chk("run.ign_count", {27'd0, lsm_count}, 32'd2);
        chk_lsm("run.ign", 1'b1, 4'd1, 1'b0, 1'b0, 1'b1);
        rst = 1'b1; wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h77; pc_inc = 1'b1;
        step();
        rst = 1'b0; wr_en = 1'b0; pc_inc = 1'b0; rn_addr = 4'd5;
        #1;
        chk_lsm("abort", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("abort.count", {27'd0, lsm_count}, 32'd0);
        chk("abort.r5", a_bus, 32'h0);
        chk("abort.pc", pc, 32'h0);
        chk("abort.st", st, 32'h1000);
        step();
        chk_lsm("abort.nodone", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
